// File: rtl/timer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : timer_pkg
// Purpose  : Shared constants and types for the timer capture path.
//            c_cnt_w_default - default timer counter / captured value width
//            log_entry_t     - one capture log entry {first, value, delta}
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package timer_pkg;

  localparam int c_cnt_w_default = 32;

  // first : entry is the first capture since reset/clear (delta forced to 0)
  // value : raw captured counter value
  // delta : value minus previous accepted value, modulo 2^width
  typedef struct packed {
    logic                       first;
    logic [c_cnt_w_default-1:0] value;
    logic [c_cnt_w_default-1:0] delta;
  } log_entry_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/capture_logger_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : capture_logger_if
// Purpose  : Capture input, read-out handshake and status bundle of the
//            capture logger.
//            clear_in      - synchronous flush of FIFO, history and flags
//            cap_valid_in  - one-cycle strobe, new captured value
//            cap_value_in  - captured counter value
//            rd_valid_out  - head entry available
//            rd_ready_in   - consumer accepts head entry
//            rd_value_out  - head captured value
//            rd_delta_out  - head interval since previous accepted capture
//            rd_first_out  - head is first capture since reset/clear
//            level_out     - FIFO occupancy
//            overflow_out  - sticky, at least one capture dropped
//            drop_cnt_out  - dropped-capture count, saturating at 255
//            master: producer/consumer side, slave: logger side
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface capture_logger_if #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 8
);

  logic                     clear_in;
  logic                     cap_valid_in;
  logic [CNT_W-1:0]         cap_value_in;
  logic                     rd_valid_out;
  logic                     rd_ready_in;
  logic [CNT_W-1:0]         rd_value_out;
  logic [CNT_W-1:0]         rd_delta_out;
  logic                     rd_first_out;
  logic [$clog2(DEPTH):0]   level_out;
  logic                     overflow_out;
  logic [7:0]               drop_cnt_out;

  modport master (
    output clear_in, cap_valid_in, cap_value_in, rd_ready_in,
    input  rd_valid_out, rd_value_out, rd_delta_out, rd_first_out,
           level_out, overflow_out, drop_cnt_out
  );

  modport slave (
    input  clear_in, cap_valid_in, cap_value_in, rd_ready_in,
    output rd_valid_out, rd_value_out, rd_delta_out, rd_first_out,
           level_out, overflow_out, drop_cnt_out
  );

endinterface : capture_logger_if
`default_nettype wire

// File: rtl/capture_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : capture_fifo
// Purpose  : Synchronous FIFO holding capture log entries.
//            clk       - clock
//            rst_n     - asynchronous active-low reset (pointers, level)
//            clear     - synchronous flush, wins over push/pop
//            push      - write push_data (ignored when full without pop)
//            push_data - entry to write
//            pop       - advance head (ignored when empty)
//            head_data - head entry, all-zero while empty
//            full      - level == DEPTH
//            empty     - level == 0
//            level     - registered occupancy
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module capture_fifo
  import timer_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type ENTRY_T = log_entry_t
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   clear,
  input  wire logic                   push,
  input  wire ENTRY_T                 push_data,
  input  wire logic                   pop,
  output ENTRY_T                      head_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_lvl_w  = c_addr_w + 1;

  ENTRY_T               r_mem [DEPTH];
  logic [c_addr_w-1:0]  r_wr_ptr;
  logic [c_addr_w-1:0]  r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_level == c_lvl_w'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_pop_ok  = pop && !w_empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign w_push_ok = push && (!w_full || w_pop_ok);

  // Storage is not reset; gating the head with empty hides stale contents.
  always_ff @(posedge clk) begin
    if (w_push_ok && !clear) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= c_addr_w'(r_wr_ptr + 1'b1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= c_addr_w'(r_rd_ptr + 1'b1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= c_lvl_w'(r_level + 1'b1);
        2'b01:   r_level <= c_lvl_w'(r_level - 1'b1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign head_data = w_empty ? ENTRY_T'('0) : r_mem[r_rd_ptr];
  assign full      = w_full;
  assign empty     = w_empty;
  assign level     = r_level;

endmodule : capture_fifo
`default_nettype wire

// File: rtl/capture_logger.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : capture_logger
// Purpose  : Logs timer capture values with the interval to the previous
//            accepted capture into a FIFO, tracking dropped captures.
//            clk_in    - single clock for all state
//            rst_an_in - asynchronous active-low reset
//            bus       - capture_logger_if.slave (capture strobe/value,
//                        read handshake, level/overflow/drop status, clear)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module capture_logger
  import timer_pkg::*;
#(
  parameter int CNT_W = c_cnt_w_default,
  parameter int DEPTH = 8
) (
  input  wire logic         clk_in,
  input  wire logic         rst_an_in,
  capture_logger_if.slave   bus
);

  localparam int c_lvl_w = $clog2(DEPTH) + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("capture_logger: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  // Same layout as log_entry_t but sized by this instance's CNT_W.
  typedef struct packed {
    logic             first;
    logic [CNT_W-1:0] value;
    logic [CNT_W-1:0] delta;
  } entry_t;

  logic [CNT_W-1:0]   r_prev;
  logic               r_first_armed;
  logic               r_overflow;
  logic [7:0]         r_drop_cnt;

  entry_t             w_push_entry;
  entry_t             w_head;
  logic               w_full;
  logic               w_empty;
  logic [c_lvl_w-1:0] w_level;
  logic               w_pop;
  logic               w_cap;
  logic               w_accept;
  logic               w_drop;

  assign w_pop    = !w_empty && bus.rd_ready_in;
  // A capture coincident with clear is discarded and not counted.
  assign w_cap    = bus.cap_valid_in && !bus.clear_in;
  assign w_accept = w_cap && (!w_full || w_pop);
  assign w_drop   = w_cap && w_full && !w_pop;

  // Unsigned subtraction wraps modulo 2^CNT_W, so a counter rollover
  // between captures still yields the true interval.
  always_comb begin
    w_push_entry       = '0;
    w_push_entry.first = r_first_armed;
    w_push_entry.value = bus.cap_value_in;
    w_push_entry.delta = r_first_armed ? '0 : (bus.cap_value_in - r_prev);
  end

  capture_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_an_in),
    .clear     (bus.clear_in),
    .push      (w_accept),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level)
  );

  // History follows accepted pushes only; drops leave it untouched.
  always_ff @(posedge clk_in or negedge rst_an_in) begin
    if (!rst_an_in) begin
      r_prev        <= '0;
      r_first_armed <= 1'b1;
      r_overflow    <= 1'b0;
      r_drop_cnt    <= '0;
    end else if (bus.clear_in) begin
      r_prev        <= '0;
      r_first_armed <= 1'b1;
      r_overflow    <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_prev        <= bus.cap_value_in;
        r_first_armed <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.rd_valid_out = !w_empty;
  assign bus.rd_value_out = w_head.value;
  assign bus.rd_delta_out = w_head.delta;
  assign bus.rd_first_out = w_head.first;
  assign bus.level_out    = w_level;
  assign bus.overflow_out = r_overflow;
  assign bus.drop_cnt_out = r_drop_cnt;

endmodule : capture_logger
`default_nettype wire

// File: tb/tb_capture_logger.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_capture_logger
// Purpose  : Directed self-checking bench for capture_logger (CNT_W=32,
//            DEPTH=8): in-order logging, wrap-around delta, overflow and
//            drop saturation, full push+pop, clear priority, async reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_capture_logger;

  localparam int c_cnt_w = 32;
  localparam int c_depth = 8;

  logic clk;
  logic rst_an;
  int   n_checks = 0;
  int   n_fail   = 0;

  capture_logger_if #(.CNT_W(c_cnt_w), .DEPTH(c_depth)) bus ();

  capture_logger #(.CNT_W(c_cnt_w), .DEPTH(c_depth)) u_dut (
    .clk_in    (clk),
    .rst_an_in (rst_an),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input logic [31:0] val,
                            input logic [31:0] dlt, input logic fst);
    check_val({tag, ".valid"}, 64'(bus.rd_valid_out), 64'd1);
    check_val({tag, ".value"}, 64'(bus.rd_value_out), 64'(val));
    check_val({tag, ".delta"}, 64'(bus.rd_delta_out), 64'(dlt));
    check_val({tag, ".first"}, 64'(bus.rd_first_out), 64'(fst));
  endtask

  task automatic do_clear();
    bus.clear_in = 1'b1;
    step();
    bus.clear_in = 1'b0;
  endtask

  function automatic logic [31:0] ovf_val(input int i);
    return 32'(i * 16 + 3);
  endfunction

  initial begin
    rst_an           = 1'b0;
    bus.clear_in     = 1'b0;
    bus.cap_valid_in = 1'b1;          // captures during reset are ignored
    bus.cap_value_in = 32'hDEAD;
    bus.rd_ready_in  = 1'b0;
    step();
    step();
    check_val("rst.valid", 64'(bus.rd_valid_out), 64'd0);
    check_val("rst.level", 64'(bus.level_out), 64'd0);
    check_val("rst.ovf",   64'(bus.overflow_out), 64'd0);
    check_val("rst.drop",  64'(bus.drop_cnt_out), 64'd0);
    check_val("rst.value", 64'(bus.rd_value_out), 64'd0);
    check_val("rst.delta", 64'(bus.rd_delta_out), 64'd0);
    check_val("rst.first", 64'(bus.rd_first_out), 64'd0);
    bus.cap_valid_in = 1'b0;
    rst_an = 1'b1;
    step();
    check_val("post_rst.level", 64'(bus.level_out), 64'd0);

    // Streaming with consumer always ready.
    bus.rd_ready_in  = 1'b1;
    bus.cap_valid_in = 1'b1;
    bus.cap_value_in = 32'd100;
    step();
    check_head("s100", 32'd100, 32'd0, 1'b1);
    check_val("s100.level", 64'(bus.level_out), 64'd1);
    bus.cap_value_in = 32'd250;
    step();
    check_head("s250", 32'd250, 32'd150, 1'b0);
    bus.cap_value_in = 32'd1000;
    step();
    check_head("s1000", 32'd1000, 32'd750, 1'b0);
    bus.cap_valid_in = 1'b0;
    step();
    check_val("s.empty", 64'(bus.rd_valid_out), 64'd0);
    check_val("s.level", 64'(bus.level_out), 64'd0);

    // Counter wrap between captures.
    do_clear();
    bus.rd_ready_in  = 1'b0;
    bus.cap_valid_in = 1'b1;
    bus.cap_value_in = 32'hFFFF_FFF0;
    step();
    bus.cap_value_in = 32'h0000_0010;
    step();
    bus.cap_valid_in = 1'b0;
    check_val("wrap.level", 64'(bus.level_out), 64'd2);
    check_head("wrap0", 32'hFFFF_FFF0, 32'd0, 1'b1);
    step();
    check_head("wrap0.hold", 32'hFFFF_FFF0, 32'd0, 1'b1);
    bus.rd_ready_in = 1'b1;
    step();
    check_head("wrap1", 32'h0000_0010, 32'h20, 1'b0);
    step();
    check_val("wrap.empty", 64'(bus.rd_valid_out), 64'd0);

    // Overflow: 10 captures into 8 entries.
    do_clear();
    bus.rd_ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.cap_valid_in = 1'b1;
      bus.cap_value_in = ovf_val(i);
      step();
    end
    bus.cap_valid_in = 1'b0;
    check_val("ovf.level", 64'(bus.level_out), 64'd8);
    check_val("ovf.flag",  64'(bus.overflow_out), 64'd1);
    check_val("ovf.drop",  64'(bus.drop_cnt_out), 64'd2);
    check_head("ovf0", ovf_val(0), 32'd0, 1'b1);

    // Full with simultaneous push and pop; delta measured from 8th value.
    bus.cap_valid_in = 1'b1;
    bus.cap_value_in = 32'd500;
    bus.rd_ready_in  = 1'b1;
    step();
    bus.cap_valid_in = 1'b0;
    check_val("fpp.level", 64'(bus.level_out), 64'd8);
    check_val("fpp.drop",  64'(bus.drop_cnt_out), 64'd2);
    for (int i = 1; i < 8; i++) begin
      check_head($sformatf("drain%0d", i), ovf_val(i), 32'd16, 1'b0);
      step();
    end
    check_head("drain500", 32'd500, 32'd385, 1'b0);
    step();
    check_val("drain.empty", 64'(bus.rd_valid_out), 64'd0);
    step();
    check_val("drain.nounder", 64'(bus.level_out), 64'd0);

    // Drop counter saturation.
    bus.rd_ready_in  = 1'b0;
    bus.cap_valid_in = 1'b1;
    for (int i = 0; i < 8 + 300; i++) begin
      bus.cap_value_in = 32'(i);
      step();
    end
    bus.cap_valid_in = 1'b0;
    check_val("sat.drop",  64'(bus.drop_cnt_out), 64'd255);
    check_val("sat.level", 64'(bus.level_out), 64'd8);

    // Clear coincident with capture at level 3.
    do_clear();
    for (int i = 1; i <= 3; i++) begin
      bus.cap_valid_in = 1'b1;
      bus.cap_value_in = 32'(i);
      step();
    end
    check_val("clr.pre_level", 64'(bus.level_out), 64'd3);
    bus.clear_in     = 1'b1;
    bus.cap_value_in = 32'd999;
    step();
    bus.clear_in     = 1'b0;
    bus.cap_valid_in = 1'b0;
    check_val("clr.level", 64'(bus.level_out), 64'd0);
    check_val("clr.ovf",   64'(bus.overflow_out), 64'd0);
    check_val("clr.drop",  64'(bus.drop_cnt_out), 64'd0);
    check_val("clr.valid", 64'(bus.rd_valid_out), 64'd0);
    bus.cap_valid_in = 1'b1;
    bus.cap_value_in = 32'd77;
    step();
    check_head("clr77", 32'd77, 32'd0, 1'b1);
    bus.cap_value_in = 32'd80;
    bus.rd_ready_in  = 1'b1;
    step();
    bus.cap_valid_in = 1'b0;
    check_head("clr80", 32'd80, 32'd3, 1'b0);
    step();
    bus.rd_ready_in = 1'b0;

    // Asynchronous reset mid-stream at level 5.
    for (int i = 1; i <= 5; i++) begin
      bus.cap_valid_in = 1'b1;
      bus.cap_value_in = 32'(i * 10);
      step();
    end
    check_val("arst.pre_level", 64'(bus.level_out), 64'd5);
    bus.cap_value_in = 32'd123;
    #2 rst_an = 1'b0;
    #1;
    check_val("arst.valid", 64'(bus.rd_valid_out), 64'd0);
    check_val("arst.level", 64'(bus.level_out), 64'd0);
    check_val("arst.value", 64'(bus.rd_value_out), 64'd0);
    check_val("arst.delta", 64'(bus.rd_delta_out), 64'd0);
    check_val("arst.first", 64'(bus.rd_first_out), 64'd0);
    step();
    step();
    rst_an           = 1'b1;
    bus.cap_valid_in = 1'b0;
    step();
    check_val("arst.post_level", 64'(bus.level_out), 64'd0);
    check_val("arst.post_valid", 64'(bus.rd_valid_out), 64'd0);
    bus.cap_valid_in = 1'b1;
    bus.cap_value_in = 32'd42;
    step();
    bus.cap_valid_in = 1'b0;
    check_head("arst42", 32'd42, 32'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_capture_logger
`default_nettype wire
